minimac2_evctl: RTL and testbench

//  Event accumulator and interrupt generator on the sys_clk side of the MAC.
//  - Consumes single-cycle pulses already resynchronised from the PHY clock domains (RX slot done, TX done, ...).
//  - Counts pending events per source and reports them over the CSR bus.
//  - Drives one level interrupt to the CPU.

---
 rtl/minimac2_evctl_pkg.sv | 14 +
 rtl/minimac2_evcnt.sv | 28 ++
 rtl/minimac2_evctl.sv | 130 +++++++++++++
 tb/tb_minimac2_evctl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/minimac2_evctl_pkg.sv
// Shared constants for the MAC event controller: CSR register offsets and bank-select field.
package minimac2_evctl_pkg;

  localparam logic [3:0] REG_STATUS  = 4'h0;
  localparam logic [3:0] REG_MASK    = 4'h1;
  localparam logic [3:0] REG_ACK     = 4'h2;
  localparam logic [3:0] REG_OVF     = 4'h3;
  localparam logic [3:0] REG_HOLDOFF = 4'h4;
  localparam logic [3:0] REG_COUNT0  = 4'h8;

  localparam int CSR_SEL_MSB = 13;
  localparam int CSR_SEL_LSB = 10;

endpackage

// File: rtl/minimac2_evcnt.sv
// One pending-event counter: saturating up/down, with an overflow flag for events lost at saturation.
module minimac2_evcnt #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_set
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A simultaneous event and ack cancel out, so neither moves the count nor flags overflow.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign ovf_set = inc && !dec && (cnt == CNT_MAX);

endmodule

// File: rtl/minimac2_evctl.sv
// MAC event accumulator and interrupt generator with CSR access.
// Optional interrupt coalescing (holdoff timer) enabled by MINIMAC2_EVCTL_COALESCE_EN.
module minimac2_evctl
  import minimac2_evctl_pkg::*;
#(
  parameter logic [3:0] CSR_ADDR = 4'h0,
  parameter int         NSRC     = 4,
  parameter int         CNT_W    = 4,
  parameter int         HOLD_W   = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [NSRC-1:0] ev_i,
  input  logic [13:0]     csr_a,
  input  logic            csr_we,
  input  logic [31:0]     csr_di,
  output logic [31:0]     csr_do,
  output logic            irq
);

  logic             sel;
  logic [3:0]       off;
  logic             wr_mask;
  logic             wr_ack;
  logic             wr_ovf;
  logic [NSRC-1:0]  ack_vec;
  logic [NSRC-1:0]  ovf_clr;
  logic [NSRC-1:0]  ovf_set;
  logic [NSRC-1:0]  status;
  logic [NSRC-1:0]  mask;
  logic [NSRC-1:0]  ovf;
  logic [CNT_W-1:0] cnt [NSRC];
  logic [31:0]      rd_data;
  logic             irq_raw;
  logic             irq_next;
  logic             unused_bits;

  assign sel     = (csr_a[CSR_SEL_MSB:CSR_SEL_LSB] == CSR_ADDR);
  assign off     = csr_a[3:0];
  assign wr_mask = sel && csr_we && (off == REG_MASK);
  assign wr_ack  = sel && csr_we && (off == REG_ACK);
  assign wr_ovf  = sel && csr_we && (off == REG_OVF);
  assign ack_vec = wr_ack ? csr_di[NSRC-1:0] : '0;
  assign ovf_clr = wr_ovf ? csr_di[NSRC-1:0] : '0;

  assign unused_bits = ^{csr_a[CSR_SEL_LSB-1:4], csr_di};

  for (genvar k = 0; k < NSRC; k++) begin : g_cnt
    minimac2_evcnt #(.CNT_W(CNT_W)) u_cnt (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .inc       (ev_i[k]),
      .dec       (ack_vec[k]),
      .cnt       (cnt[k]),
      .ovf_set   (ovf_set[k])
    );
  end

  always_comb begin
    status = '0;
    for (int k = 0; k < NSRC; k++) status[k] = (cnt[k] != '0);
  end

  assign irq_raw = |(status & mask);

  // Set wins over a same-cycle W1C on the same bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask <= '0;
      ovf  <= '0;
    end else begin
      if (wr_mask) mask <= csr_di[NSRC-1:0];
      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

`ifdef MINIMAC2_EVCTL_COALESCE_EN
  localparam logic [HOLD_W-1:0] TIMER_MAX = '1;

  logic              wr_holdoff;
  logic [HOLD_W-1:0] holdoff;
  logic [HOLD_W-1:0] timer;

  assign wr_holdoff = sel && csr_we && (off == REG_HOLDOFF);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      holdoff <= '0;
      timer   <= '0;
    end else begin
      if (wr_holdoff) holdoff <= csr_di[HOLD_W-1:0];
      if (!irq_raw)                timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + 1'b1;
    end
  end

  assign irq_next = irq_raw && (timer >= holdoff);
`else
  assign irq_next = irq_raw;
`endif

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (off)
        REG_STATUS:  rd_data = 32'(status);
        REG_MASK:    rd_data = 32'(mask);
        REG_OVF:     rd_data = 32'(ovf);
`ifdef MINIMAC2_EVCTL_COALESCE_EN
        REG_HOLDOFF: rd_data = 32'(holdoff);
`endif
        default:     rd_data = '0;
      endcase
      for (int k = 0; k < NSRC; k++) begin
        if (off == 4'(REG_COUNT0 + k)) rd_data = 32'(cnt[k]);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_do <= '0;
      irq    <= 1'b0;
    end else begin
      csr_do <= rd_data;
      irq    <= irq_next;
    end
  end

endmodule

// File: tb/tb_minimac2_evctl.sv
// Directed self-checking bench for minimac2_evctl (NSRC=4, CNT_W=4, bank 2).
// Coalescing checks compile in when MINIMAC2_EVCTL_COALESCE_EN is defined.
module tb_minimac2_evctl;

  localparam logic [3:0] BANK  = 4'h2;
  localparam logic [3:0] OTHER = 4'h3;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  ev_i;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;

  int n_chk;
  int n_bad;

  minimac2_evctl #(
    .CSR_ADDR (BANK),
    .NSRC     (4),
    .CNT_W    (4),
    .HOLD_W   (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ev_i      (ev_i),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .irq       (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] adr(input logic [3:0] bank, input logic [3:0] off);
    return {bank, 6'd0, off};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
    csr_a  = a;
    csr_we = 1'b0;
    tick();
    d = csr_do;
  endtask

  task automatic pulse(input int k);
    ev_i = 4'(1 << k);
    tick();
    ev_i = '0;
  endtask

  logic [31:0] rd;
  int          n;

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    sys_rst_n = 1'b0;
    ev_i      = '0;
    csr_a     = '0;
    csr_we    = 1'b0;
    csr_di    = '0;
    #12;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_do", csr_do, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Saturation on source 1
    for (int i = 0; i < 17; i++) pulse(1);
    csr_rd(adr(BANK, 4'h9), rd);   chk("sat_cnt1", rd, 32'd15);
    csr_rd(adr(BANK, 4'h3), rd);   chk("sat_ovf", rd, 32'h2);
    csr_rd(adr(BANK, 4'h0), rd);   chk("sat_status", rd, 32'h2);
    csr_wr(adr(BANK, 4'h3), 32'h2);
    csr_rd(adr(BANK, 4'h3), rd);   chk("ovf_w1c", rd, 32'h0);

    // Simultaneous event and ack on a saturated source 2
    for (int i = 0; i < 15; i++) pulse(2);
    ev_i   = 4'h4;
    csr_a  = adr(BANK, 4'h2);
    csr_di = 32'h4;
    csr_we = 1'b1;
    tick();
    ev_i   = '0;
    csr_we = 1'b0;
    csr_rd(adr(BANK, 4'hA), rd);   chk("evack_cnt2", rd, 32'd15);
    csr_rd(adr(BANK, 4'h3), rd);   chk("evack_ovf", rd, 32'h0);
    csr_wr(adr(BANK, 4'h2), 32'hC);
    csr_rd(adr(BANK, 4'hA), rd);   chk("ack_cnt2", rd, 32'd14);
    csr_rd(adr(BANK, 4'hB), rd);   chk("ack_zero_cnt3", rd, 32'd0);
    csr_rd(adr(BANK, 4'h2), rd);   chk("ack_reads0", rd, 32'd0);

    // Interrupt latency and masking
    csr_wr(adr(BANK, 4'h1), 32'h1);
    chk("irq_pre", 32'(irq), 32'd0);
    pulse(0);
    chk("irq_lat1", 32'(irq), 32'd0);
    tick();
    chk("irq_lat2", 32'(irq), 32'd1);
    csr_wr(adr(BANK, 4'h2), 32'h1);
    chk("irq_ack0", 32'(irq), 32'd1);
    tick();
    chk("irq_ack1", 32'(irq), 32'd0);
    csr_wr(adr(BANK, 4'h1), 32'h0);
    pulse(0);
    for (int i = 0; i < 4; i++) begin
      chk("irq_masked", 32'(irq), 32'd0);
      tick();
    end
    csr_wr(adr(BANK, 4'h1), 32'h1);
    chk("mask_wr0", 32'(irq), 32'd0);
    tick();
    chk("mask_wr1", 32'(irq), 32'd1);

    // Bank decode and unmapped offsets
    csr_rd(adr(OTHER, 4'h1), rd);  chk("bank_rd", rd, 32'd0);
    csr_wr(adr(OTHER, 4'h1), 32'hF);
    csr_rd(adr(BANK, 4'h1), rd);   chk("bank_wr_mask", rd, 32'h1);
    csr_rd(adr(BANK, 4'h5), rd);   chk("unmapped", rd, 32'd0);
    csr_rd(adr(BANK, 4'hC), rd);   chk("count_oob", rd, 32'd0);
    csr_wr(adr(BANK, 4'h4), 32'd10);
    csr_rd(adr(BANK, 4'h4), rd);
`ifdef MINIMAC2_EVCTL_COALESCE_EN
    chk("holdoff_rd", rd, 32'd10);
    csr_wr(adr(BANK, 4'h4), 32'd0);
`else
    chk("holdoff_rd", rd, 32'd0);
`endif

    // Reset mid-operation
    pulse(0);
    pulse(0);
    csr_rd(adr(BANK, 4'h8), rd);   chk("cnt0_pre", rd, 32'd3);
    chk("irq_pre_rst", 32'(irq), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_do", csr_do, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    csr_rd(adr(BANK, 4'h8), rd);   chk("rst_cnt0", rd, 32'd0);
    csr_rd(adr(BANK, 4'h1), rd);   chk("rst_mask", rd, 32'd0);
    csr_rd(adr(BANK, 4'h3), rd);   chk("rst_ovf", rd, 32'd0);

`ifdef MINIMAC2_EVCTL_COALESCE_EN
    // Coalescing: holdoff delays irq, an early ack suppresses it
    csr_wr(adr(BANK, 4'h4), 32'd10);
    csr_wr(adr(BANK, 4'h1), 32'h1);
    pulse(0);
    n = 0;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("coal_lat_ok", 32'(n >= 11 && n <= 12), 32'd1);
    csr_wr(adr(BANK, 4'h2), 32'h1);
    tick();
    chk("coal_drop", 32'(irq), 32'd0);
    pulse(0);
    for (int i = 0; i < 4; i++) tick();
    csr_wr(adr(BANK, 4'h2), 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (irq) n++;
      tick();
    end
    chk("coal_never", 32'(n), 32'd0);
    pulse(0);
    n = 0;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("coal_restart_ok", 32'(n >= 11 && n <= 12), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
